// File: rtl/apb_pkg.sv
// Shared types for the APB master controller: FSM state encoding, request record
// and the "no slave selected" code.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  localparam logic [1:0] SelNone = 2'b00;

  typedef struct packed {
    logic       write;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] wait_cycles;
  } apb_req_t;

  // A request addressed to no slave is answered with an error and never reaches the bus.
  function automatic logic req_valid(input apb_req_t req);
    return req.sel != SelNone;
  endfunction

endpackage

// File: rtl/apb_req_slot.sv
// One-entry request buffer holding a start that arrives while a transfer is in flight.
module apb_req_slot
  import apb_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     load_i,
  input  logic     pop_i,
  input  apb_req_t data_i,
  output logic     full_o,
  output apb_req_t data_o
);

  logic     full_q, full_d;
  apb_req_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: turns single-cycle processor start pulses into APB SETUP/ACCESS transfers,
// with a one-deep pending slot and a per-transfer ACCESS timeout.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       proc_start,
  input  logic       proc_write,
  input  logic [1:0] proc_sel,
  input  logic [7:0] proc_addr,
  input  logic [7:0] proc_wdata,
  input  logic [7:0] proc_wait_cycles,
  output logic [7:0] proc_rdata,
  output logic       proc_ready,
  output logic       proc_err,
  output logic       proc_busy,
  output logic       apb_write,
  output logic [1:0] apb_sel,
  output logic [7:0] apb_addr,
  output logic [7:0] apb_wdata,
  output logic [7:0] apb_wait_cycles,
  output logic       apb_enable,
  input  logic       apb_ready,
  input  logic [7:0] apb_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  apb_state_e     state_q, state_d;
  apb_req_t       act_q, act_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           err_q, err_d;

  apb_req_t proc_req;
  apb_req_t slot_req;
  apb_req_t next_req;
  logic     next_avail;
  logic     slot_full;
  logic     slot_load;
  logic     slot_pop;

  assign proc_req.write       = proc_write;
  assign proc_req.sel         = proc_sel;
  assign proc_req.addr        = proc_addr;
  assign proc_req.wdata       = proc_wdata;
  assign proc_req.wait_cycles = proc_wait_cycles;

  // Only starts landing mid-transfer are parked; in RESP an empty slot is bypassed
  // so the new request goes straight into SETUP on the next cycle.
  assign slot_load = proc_start && !slot_full &&
                     ((state_q == StSetup) || (state_q == StAccess));

  // The pending slot always has priority over a simultaneous new start.
  assign next_req   = slot_full ? slot_req : proc_req;
  assign next_avail = slot_full || proc_start;

  apb_req_slot u_slot (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (slot_load),
    .pop_i   (slot_pop),
    .data_i  (proc_req),
    .full_o  (slot_full),
    .data_o  (slot_req)
  );

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    slot_pop = 1'b0;

    unique case (state_q)
      StIdle, StResp: begin
        if (next_avail) begin
          slot_pop = slot_full;
          if (req_valid(next_req)) begin
            act_d   = next_req;
            cnt_d   = '0;
            state_d = StSetup;
          end else begin
            rdata_d = 8'h00;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end else begin
          state_d = StIdle;
        end
      end

      StSetup: begin
        state_d = StAccess;
      end

      StAccess: begin
        if (apb_ready) begin
          rdata_d = act_q.write ? 8'h00 : apb_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q >= CntLast) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      act_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The bus is only driven while a transfer is on it; everywhere else it reads as zero.
  always_comb begin
    apb_write       = 1'b0;
    apb_sel         = SelNone;
    apb_addr        = 8'h00;
    apb_wdata       = 8'h00;
    apb_wait_cycles = 8'h00;
    apb_enable      = 1'b0;
    if ((state_q == StSetup) || (state_q == StAccess)) begin
      apb_write       = act_q.write;
      apb_sel         = act_q.sel;
      apb_addr        = act_q.addr;
      apb_wdata       = act_q.wdata;
      apb_wait_cycles = act_q.wait_cycles;
      apb_enable      = (state_q == StAccess);
    end
  end

  always_comb begin
    proc_ready = (state_q == StResp);
    proc_rdata = proc_ready ? rdata_q : 8'h00;
    proc_err   = proc_ready && err_q;
    proc_busy  = slot_full;
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: a driver pushes expected responses computed from
// the transfer rules, a monitor checks every proc_ready pulse and the APB request lines.
module tb_apb_master_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       proc_start = 1'b0;
  logic       proc_write = 1'b0;
  logic [1:0] proc_sel = 2'b00;
  logic [7:0] proc_addr = 8'h00;
  logic [7:0] proc_wdata = 8'h00;
  logic [7:0] proc_wait_cycles = 8'h00;
  logic [7:0] proc_rdata;
  logic       proc_ready;
  logic       proc_err;
  logic       proc_busy;
  logic       apb_write;
  logic [1:0] apb_sel;
  logic [7:0] apb_addr;
  logic [7:0] apb_wdata;
  logic [7:0] apb_wait_cycles;
  logic       apb_enable;
  logic       apb_ready = 1'b0;
  logic [7:0] apb_rdata = 8'h00;

  always #5 clk = ~clk;

  apb_master_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .proc_start       (proc_start),
    .proc_write       (proc_write),
    .proc_sel         (proc_sel),
    .proc_addr        (proc_addr),
    .proc_wdata       (proc_wdata),
    .proc_wait_cycles (proc_wait_cycles),
    .proc_rdata       (proc_rdata),
    .proc_ready       (proc_ready),
    .proc_err         (proc_err),
    .proc_busy        (proc_busy),
    .apb_write        (apb_write),
    .apb_sel          (apb_sel),
    .apb_addr         (apb_addr),
    .apb_wdata        (apb_wdata),
    .apb_wait_cycles  (apb_wait_cycles),
    .apb_enable       (apb_enable),
    .apb_ready        (apb_ready),
    .apb_rdata        (apb_rdata)
  );

  typedef struct {
    bit       write;
    bit [1:0] sel;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit [7:0] waitc;
    bit [7:0] rdata;
    bit       err;
    int       resp_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_resp = 0;
  bit   mon_en = 1'b0;
  int   acc_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit [7:0] rd_fn(input bit [1:0] sel, input bit [7:0] addr);
    return addr + 8'h9C + {sel, 6'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: ready in ACCESS cycle wait_cycles+1; random junk on ready/rdata outside ACCESS.
  always @(negedge clk) begin
    if (apb_enable) begin
      acc_n++;
      apb_ready = (acc_n == int'(apb_wait_cycles) + 1);
      apb_rdata = rd_fn(apb_sel, apb_addr);
    end else begin
      acc_n = 0;
      apb_ready = 1'($urandom_range(0, 1));
      apb_rdata = 8'($urandom);
    end
  end

  // Monitor: q[0] is always the request currently owning the bus or being answered.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("proc_busy", 32'(proc_busy), 32'(q.size() == 2));
      if (apb_enable) begin
        if (q.size() == 0) begin
          chk("enable_without_request", 32'(apb_enable), 32'd0);
        end else begin
          chk("apb_request", {13'd0, apb_write, apb_sel, apb_addr, apb_wdata, apb_wait_cycles},
              {13'd0, q[0].write, q[0].sel, q[0].addr, q[0].wdata, q[0].waitc});
        end
      end
      if (proc_ready) begin
        chk("resp_bus_idle", {29'd0, apb_sel, apb_enable}, 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_proc_ready", 32'(proc_ready), 32'd0);
        end else begin
          e = q.pop_front();
          chk("proc_rdata", 32'(proc_rdata), 32'(e.rdata));
          chk("proc_err", 32'(proc_err), 32'(e.err));
          chk("resp_cycle", cyc, e.resp_cyc);
        end
      end else if (q.size() == 0) begin
        chk("idle_bus", {29'd0, apb_sel, apb_enable}, 32'd0);
      end
      while (q.size() > 0 && cyc > q[0].resp_cyc) begin
        e = q.pop_front();
        chk("missing_proc_ready", cyc, e.resp_cyc);
      end
    end
  end

  // One cycle of stimulus. A start is accepted when fewer than two requests are
  // outstanding, counting the one being answered this cycle.
  task automatic step(input bit start, input bit wr, input bit [1:0] sel, input bit [7:0] addr,
                      input bit [7:0] wdata, input bit [7:0] waitc);
    exp_t e;
    int   k;
    int   base;
    @(negedge clk);
    #1;
    proc_start       = start;
    proc_write       = wr;
    proc_sel         = sel;
    proc_addr        = addr;
    proc_wdata       = wdata;
    proc_wait_cycles = waitc;
    if (start && (q.size() + (proc_ready ? 1 : 0)) < 2) begin
      e.write = wr;
      e.sel   = sel;
      e.addr  = addr;
      e.wdata = wdata;
      e.waitc = waitc;
      e.err   = (sel == 2'b00) || (int'(waitc) + 1 > int'(TIMEOUT));
      e.rdata = (e.err || wr) ? 8'h00 : rd_fn(sel, addr);
      k = (int'(waitc) + 1 < int'(TIMEOUT)) ? int'(waitc) + 1 : int'(TIMEOUT);
      base = (cyc > last_resp) ? cyc : last_resp;
      e.resp_cyc = base + ((sel == 2'b00) ? 1 : 2 + k);
      last_resp = e.resp_cyc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {8'd0, proc_rdata, proc_ready, proc_err, proc_busy, apb_write, apb_sel,
               apb_enable, 1'b0},
        32'd0);
    chk({name, "_bus"}, {8'd0, apb_addr, apb_wdata, apb_wait_cycles}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    proc_start = 1'b0;
    reset      = 1'b1;
    q.delete();
    last_resp  = 0;
    @(negedge clk);
    #1;
    chk_all_zero("reset_outputs");
    reset = 1'b0;
  endtask

  initial begin
    bit       wr;
    bit [1:0] sel;
    bit [7:0] waitc;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("initial_reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Zero-wait write: proc_ready three cycles after the start edge.
    step(1'b1, 1'b1, 2'b01, 8'h10, 8'hA5, 8'd0);
    idle(5);
    // Read with three ACCESS cycles, slave returns 0x3C.
    step(1'b1, 1'b0, 2'b10, 8'h20, 8'h00, 8'd2);
    idle(8);
    // Back-to-back: second start lands in ACCESS, third hits a full slot and is dropped.
    step(1'b1, 1'b0, 2'b01, 8'h44, 8'h00, 8'd3);
    idle(1);
    step(1'b1, 1'b1, 2'b10, 8'h55, 8'h66, 8'd0);
    step(1'b1, 1'b1, 2'b11, 8'h77, 8'h88, 8'd0);
    idle(12);
    // Invalid select, then a slave that never answers.
    step(1'b1, 1'b0, 2'b00, 8'h01, 8'h00, 8'd0);
    idle(3);
    step(1'b1, 1'b0, 2'b11, 8'h02, 8'h00, 8'd255);
    idle(9);
    // Start in the RESP cycle of a zero-wait read goes straight to SETUP.
    step(1'b1, 1'b0, 2'b01, 8'h03, 8'h00, 8'd0);
    idle(2);
    step(1'b1, 1'b0, 2'b10, 8'h04, 8'h00, 8'd1);
    idle(8);
    // Reset while in ACCESS with the slot occupied; nothing may answer afterwards.
    step(1'b1, 1'b0, 2'b01, 8'h30, 8'h00, 8'd200);
    idle(1);
    step(1'b1, 1'b1, 2'b10, 8'h31, 8'h32, 8'd0);
    idle(1);
    do_reset();
    idle(3);
    step(1'b1, 1'b0, 2'b11, 8'h40, 8'h00, 8'd1);
    idle(8);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        wr    = 1'($urandom_range(0, 1));
        sel   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        waitc = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
        step(1'b1, wr, sel, 8'($urandom), 8'($urandom), waitc);
      end else begin
        idle(1);
      end
    end

    for (int i = 0; i < 100 && q.size() > 0; i++) idle(1);
    idle(2);
    chk("drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB master controller bridging the processor-side request bus to the APB bus. Accepts single-cycle start requests (address, data, direction, slave select, wait-cycle hint), runs the APB SETUP/ACCESS sequence toward the selected slave, and returns read data plus a one-cycle completion pulse. A one-deep pending slot absorbs a request issued while a transfer is in flight; a timeout counter aborts transfers to a slave that never asserts ready.

## Interface
Parameters:
- TIMEOUT, 64: max ACCESS cycles waiting for apb_ready before abort (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- proc_start  in  1  request pulse; sampled with proc_write/sel/addr/wdata/wait_cycles.
- proc_write  in  1  1 = write, 0 = read.
- proc_sel  in  2  slave select code; 2'b00 = no slave (invalid).
- proc_addr  in  8  transfer address.
- proc_wdata  in  8  write data.
- proc_wait_cycles  in  8  wait-cycle hint forwarded to slave.
- proc_rdata  out  8  read data, valid while proc_ready=1.
- proc_ready  out  1  one-cycle completion pulse.
- proc_err  out  1  valid with proc_ready; 1 = invalid sel or timeout.
- proc_busy  out  1  pending slot full; further starts dropped.
- apb_write, apb_sel[2], apb_addr[8], apb_wdata[8], apb_wait_cycles[8], apb_enable  out  APB request signals.
- apb_ready  in  1  slave completion.
- apb_rdata  in  8  slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: request available (new proc_start or pending slot) → SETUP; apb_sel=00, apb_enable=0.
- SETUP (exactly 1 cycle): apb_sel/addr/write/wdata/wait_cycles driven from active request, apb_enable=0 → ACCESS.
- ACCESS: apb_enable=1, all request signals stable. apb_ready=1 → capture apb_rdata (reads) / 0 (writes), → RESP. Timeout counter reaches TIMEOUT without apb_ready → abort, err=1, rdata=0, → RESP.
- RESP (1 cycle): proc_ready=1, proc_rdata/proc_err valid, apb_enable=0, apb_sel=00. Next: pending present → SETUP, else IDLE.
- proc_sel=00 on accepted start: no APB cycle; IDLE → RESP directly with err=1, rdata=0.
- Pending slot: proc_start while FSM not IDLE and slot empty → captured, proc_busy=1. Slot consumed on RESP→SETUP. proc_start while slot full → ignored (no response ever). proc_start in IDLE goes straight to active register; slot unused.
- Simultaneous: proc_start in the RESP cycle with empty slot → captured into slot, served next (RESP→SETUP).
- Timeout counter: 8-bit+, cleared on SETUP entry, increments each ACCESS cycle, saturates.

## Timing
- Reset (sync, takes effect at next edge, overrides all): state IDLE, slot empty, all outputs 0 (apb_sel=00, apb_enable=0, proc_ready=0, proc_err=0, proc_busy=0, proc_rdata=0, apb_addr/wdata/wait_cycles=0). Reset mid-transfer abandons it with no proc_ready.
- proc_start sampled at edge N (IDLE) → SETUP cycle N+1 → ACCESS N+2.
- apb_ready sampled high at edge M (in ACCESS) → proc_ready high cycle M+1 (RESP).
- Zero-wait slave: start→proc_ready = 3 cycles.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then RESP.
- Back-to-back via slot: RESP → SETUP, no IDLE gap; apb_enable low for RESP+SETUP.
- apb_rdata/apb_ready ignored outside ACCESS.

## Structure
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), SEL_NONE=2'b00, request struct {write, sel, addr, wdata, wait_cycles}.
- Sub-module apb_req_slot: one-entry request buffer (load, pop, full, data out); top holds FSM, active request register, timeout counter.

## Test plan
- Write: start write sel=01 addr=0x10 wdata=0xA5, slave ready in first ACCESS → SETUP at N+1, enable at N+2, proc_ready at N+3, err=0.
- Read with waits: read sel=10 addr=0x20, slave ready after 3 ACCESS cycles returning 0x3C → proc_rdata=0x3C with proc_ready, signals stable throughout ACCESS.
- Back-to-back: second start during ACCESS → proc_busy=1, RESP then immediate SETUP for second request; third start while busy → dropped, exactly two proc_ready pulses.
- Invalid/timeout: start sel=00 → proc_ready+err next cycle, apb_sel never nonzero; sel=11 with slave never ready, TIMEOUT=4 → 4 ACCESS cycles, proc_ready with err=1, rdata=0.
- Reset mid-ACCESS with slot full → next cycle all outputs 0, IDLE, no proc_ready; new start afterwards completes normally.
